subckt_stim_checker: RTL and testbench

//  Stimulus source and response checker for the 4-input power-experiment sub-circuits.

---
 rtl/subckt_stim_checker.sv | 177 +++++++++++++++++
 tb/tb_subckt_stim_checker.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/subckt_stim_checker.sv
// LFSR stimulus source and golden-model response checker for 4-input sub-circuits.
// Optional toggle-activity counter is built only when STIM_TOGGLE_CNT_EN is defined.
module subckt_stim_checker #(
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int          NUM_VEC_W = 16,
    parameter int          DUT_LAT   = 1,
    parameter int          CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [NUM_VEC_W-1:0] num_vec,
    output logic [3:0]           stim,
    input  logic                 dut_out,
    output logic                 busy,
    output logic                 done,
    output logic                 err_flag,
    output logic [CNT_W-1:0]     err_cnt,
    output logic [NUM_VEC_W-1:0] first_err_idx,
    output logic [CNT_W-1:0]     tog_cnt
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

    localparam logic [2:0] DRAIN_LAST = 3'((DUT_LAT > 0) ? DUT_LAT - 1 : 0);

    state_t                state_reg, state_next;
    logic [15:0]           lfsr_reg;
    logic [3:0]            stim_reg;
    logic [NUM_VEC_W-1:0]  num_vec_reg;
    logic [NUM_VEC_W-1:0]  vec_idx_reg;
    logic [2:0]            drain_cnt_reg;
    logic                  err_flag_reg;
    logic [CNT_W-1:0]      err_cnt_reg;
    logic [NUM_VEC_W-1:0]  first_err_reg;
    logic                  accept;
    logic                  last_vec;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    assign accept   = (state_reg == IDLE) && start;
    assign last_vec = (vec_idx_reg == num_vec_reg - 1'b1);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = (num_vec != '0) ? RUN : FIN;
            RUN:     if (last_vec) state_next = (DUT_LAT == 0) ? FIN : DRAIN;
            DRAIN:   if (drain_cnt_reg == DRAIN_LAST) state_next = FIN;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            lfsr_reg      <= LFSR_SEED;
            stim_reg      <= '0;
            num_vec_reg   <= '0;
            vec_idx_reg   <= '0;
            drain_cnt_reg <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: if (start) begin
                    num_vec_reg <= num_vec;
                    vec_idx_reg <= '0;
                    if (num_vec != '0) begin
                        // Vector 0 is the seed itself; the LFSR advances as it is issued.
                        stim_reg <= LFSR_SEED[3:0];
                        lfsr_reg <= lfsr_step(LFSR_SEED);
                    end
                end
                RUN: begin
                    drain_cnt_reg <= '0;
                    if (!last_vec) begin
                        stim_reg    <= lfsr_reg[3:0];
                        lfsr_reg    <= lfsr_step(lfsr_reg);
                        vec_idx_reg <= vec_idx_reg + 1'b1;
                    end
                end
                DRAIN:   drain_cnt_reg <= drain_cnt_reg + 1'b1;
                default: ;
            endcase
        end
    end

    // Delay line: stage 0 is the vector currently on stim, stage DUT_LAT lines up with dut_out.
    logic                 pipe_valid [0:DUT_LAT];
    logic                 pipe_exp   [0:DUT_LAT];
    logic [NUM_VEC_W-1:0] pipe_idx   [0:DUT_LAT];

    assign pipe_valid[0] = (state_reg == RUN);
    assign pipe_exp[0]   = stim_reg[0] ^ ((stim_reg[0] ^ stim_reg[1]) & (stim_reg[2] ^ stim_reg[3]));
    assign pipe_idx[0]   = vec_idx_reg;

    generate
        for (genvar gi = 1; gi <= DUT_LAT; gi++) begin : g_delay
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    pipe_valid[gi] <= 1'b0;
                    pipe_exp[gi]   <= 1'b0;
                    pipe_idx[gi]   <= '0;
                end else begin
                    pipe_valid[gi] <= pipe_valid[gi-1];
                    pipe_exp[gi]   <= pipe_exp[gi-1];
                    pipe_idx[gi]   <= pipe_idx[gi-1];
                end
            end
        end
    endgenerate

    logic cmp_valid;
    logic cmp_miss;

    assign cmp_valid = pipe_valid[DUT_LAT];
    assign cmp_miss  = cmp_valid && (dut_out != pipe_exp[DUT_LAT]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_flag_reg  <= 1'b0;
            err_cnt_reg   <= '0;
            first_err_reg <= '0;
        end else if (accept) begin
            err_flag_reg  <= 1'b0;
            err_cnt_reg   <= '0;
            first_err_reg <= '0;
        end else if (cmp_miss) begin
            err_flag_reg <= 1'b1;
            if (err_cnt_reg != '1) err_cnt_reg <= err_cnt_reg + 1'b1;
            if (!err_flag_reg) first_err_reg <= pipe_idx[DUT_LAT];
        end
    end

`ifdef STIM_TOGGLE_CNT_EN
    logic [3:0]       stim_prev_reg;
    logic             dut_prev_reg;
    logic [CNT_W-1:0] tog_reg;
    logic [2:0]       tog_inc;
    logic [CNT_W:0]   tog_sum;

    always_comb begin
        tog_inc = {2'b0, stim_reg[0] ^ stim_prev_reg[0]} + {2'b0, stim_reg[1] ^ stim_prev_reg[1]}
                + {2'b0, stim_reg[2] ^ stim_prev_reg[2]} + {2'b0, stim_reg[3] ^ stim_prev_reg[3]}
                + {2'b0, dut_out ^ dut_prev_reg};
        tog_sum = {1'b0, tog_reg} + (CNT_W+1)'(tog_inc);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stim_prev_reg <= '0;
            dut_prev_reg  <= 1'b0;
            tog_reg       <= '0;
        end else begin
            stim_prev_reg <= stim_reg;
            dut_prev_reg  <= dut_out;
            if (accept) tog_reg <= '0;
            else if (cmp_valid) tog_reg <= tog_sum[CNT_W] ? '1 : tog_sum[CNT_W-1:0];
        end
    end

    assign tog_cnt = tog_reg;
`else
    assign tog_cnt = '0;
`endif

    assign stim          = stim_reg;
    assign busy          = (state_reg == RUN) || (state_reg == DRAIN);
    assign done          = (state_reg == FIN);
    assign err_flag      = err_flag_reg;
    assign err_cnt       = err_cnt_reg;
    assign first_err_idx = first_err_reg;

endmodule

// File: tb/tb_subckt_stim_checker.sv
// Self-checking bench: behavioural sub-circuit with fault injection, reference model of vectors and errors.
module tb_subckt_stim_checker;
    localparam int          LAT  = 1;
    localparam logic [15:0] SEED = 16'hACE1;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] num_vec;
    logic [3:0]  stim;
    logic        dut_out;
    logic        busy, done, err_flag;
    logic [15:0] err_cnt, first_err_idx, tog_cnt;

    int total = 0;
    int bad   = 0;
    int dut_mode = 0;   // 0 golden, 2 stuck at 0, otherwise golden xor flip_now
    bit flip_now = 1'b0;

    subckt_stim_checker #(.LFSR_SEED(SEED), .NUM_VEC_W(16), .DUT_LAT(LAT), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .num_vec(num_vec), .stim(stim),
        .dut_out(dut_out), .busy(busy), .done(done), .err_flag(err_flag),
        .err_cnt(err_cnt), .first_err_idx(first_err_idx), .tog_cnt(tog_cnt)
    );

    always #5 clk = ~clk;

    function automatic bit gold(input logic [3:0] s);
        return s[0] ^ ((s[0] ^ s[1]) & (s[2] ^ s[3]));
    endfunction

    function automatic logic [15:0] next_lfsr(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    // Registered sub-circuit under test (one cycle of latency).
    always @(posedge clk) begin
        if (rst) dut_out <= 1'b0;
        else     dut_out <= (dut_mode == 2) ? 1'b0 : (gold(stim) ^ flip_now);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic run(input int n, input int mode, input int flip_k);
        logic [3:0]  vec [0:127];
        bit          fl  [0:127];
        logic [15:0] l;
        int          exp_err, exp_first, exp_tog, done_cyc, cyc, stim_bad, busy_bad;
        logic [3:0]  prev_stim;
        logic        prev_dut;
        bit          e, r;
        l = SEED; exp_err = 0; exp_first = 0; exp_tog = 0;
        for (int k = 0; k < n; k++) begin
            vec[k] = l[3:0];
            fl[k]  = (mode == 1) ? (k == flip_k) : (mode == 3) ? ($urandom_range(0, 3) == 0) : 1'b0;
            e = gold(vec[k]);
            r = (mode == 2) ? 1'b0 : (e ^ fl[k]);
            if (r != e) begin
                if (exp_err == 0) exp_first = k;
                exp_err++;
            end
            l = next_lfsr(l);
        end
        dut_mode = mode;
        @(negedge clk);
        prev_stim = stim; prev_dut = dut_out;
        start = 1'b1; num_vec = 16'(n);
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1; done_cyc = -1; stim_bad = 0; busy_bad = 0;
        while (cyc <= n + LAT + 5 && done_cyc < 0) begin
            flip_now = (cyc - 1 < n) ? fl[cyc-1] : 1'b0;
            if (cyc == 4) begin start = 1'b0; num_vec = 16'(n); end
            @(negedge clk);
            if (cyc - 1 < n && stim !== vec[cyc-1]) stim_bad++;
            if (busy !== (cyc <= n + LAT)) busy_bad++;
            if (cyc >= 1 + LAT && cyc <= n + LAT)
                exp_tog += $countones(stim ^ prev_stim) + int'(dut_out != prev_dut);
            prev_stim = stim; prev_dut = dut_out;
            if (done === 1'b1) done_cyc = cyc;
            if (cyc == 3 && n > 5) begin start = 1'b1; num_vec = 16'd3; end  // ignored while busy
            if (done_cyc >= 0) begin start = 1'b1; num_vec = 16'd5; end       // ignored in done cycle
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0; flip_now = 1'b0;
        check("done_cycle", 64'(done_cyc), 64'(n + 1 + LAT));
        check("stim_seq", 64'(stim_bad), 64'd0);
        check("busy_shape", 64'(busy_bad), 64'd0);
        check("err_cnt", 64'(err_cnt), 64'(exp_err));
        check("err_flag", 64'(err_flag), 64'(exp_err != 0));
        check("first_err_idx", 64'(first_err_idx), 64'(exp_first));
`ifdef STIM_TOGGLE_CNT_EN
        check("tog_cnt", 64'(tog_cnt), 64'(exp_tog));
`else
        check("tog_cnt_off", 64'(tog_cnt), 64'd0);
`endif
        @(negedge clk);
        check("done_pulse_end", 64'(done), 64'd0);
        check("busy_after_done_start", 64'(busy), 64'd0);
        check("err_cnt_hold", 64'(err_cnt), 64'(exp_err));
        $display("run n=%0d mode=%0d err_cnt=%0d first=%0d done_at=%0d exp_tog=%0d",
                 n, mode, err_cnt, first_err_idx, done_cyc, exp_tog);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; num_vec = '0;
        repeat (3) @(negedge clk);
        check("rst_stim", 64'(stim), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'({err_flag, err_cnt, first_err_idx, tog_cnt}), 64'd0);
        rst = 1'b0;
        $display("reset released");

        run(100, 0, -1);
        run(20, 1, 5);
        run(16, 2, -1);

        // Zero-length run clears results and pulses done without going busy.
        @(negedge clk);
        start = 1'b1; num_vec = 16'd0;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("zero_done", 64'(done), 64'd1);
        check("zero_busy", 64'(busy), 64'd0);
        check("zero_err_cnt", 64'(err_cnt), 64'd0);
        check("zero_err_flag", 64'(err_flag), 64'd0);
        @(negedge clk);
        check("zero_done_end", 64'(done), 64'd0);
        $display("run n=0 done pulse observed=%0d", total);

        for (int i = 0; i < 4; i++) run($urandom_range(1, 60), 3, -1);

        // Asynchronous reset in the middle of a failing run.
        dut_mode = 2;
        @(negedge clk);
        start = 1'b1; num_vec = 16'd100;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (40) @(posedge clk);
        @(negedge clk);
        check("pre_rst_busy", 64'(busy), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("midrst_stim", 64'(stim), 64'd0);
        check("midrst_flags", 64'({busy, done, err_flag}), 64'd0);
        check("midrst_cnts", 64'({err_cnt, first_err_idx, tog_cnt}), 64'd0);
        @(negedge clk);
        rst = 1'b0; dut_mode = 0;
        $display("mid-run reset at vector 40 applied");

        run(100, 0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
